// File: rtl/fetch_ctrl_if.sv
// Datapath-facing bus of the fetch/control stage: next-PC operands in,
// architectural PC, link value, ROM address and the retire strobe out.
interface fetch_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 6
);
    // Handshake: there is no valid/ready pair. commit is a one-cycle strobe
    // that qualifies npc_sel/br_taken/imm/rs1_val in the same cycle; those
    // operands must be stable then, and any state write in the core is
    // allowed only while commit is high.
    logic [1:0]        npc_sel;
    logic              br_taken;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
    logic [ADDR_W-1:0] rom_addr;
    logic              commit;

    modport master (
        input  npc_sel,
        input  br_taken,
        input  imm,
        input  rs1_val,
        output pc,
        output pc_plus4,
        output rom_addr,
        output commit
    );

    modport slave (
        output npc_sel,
        output br_taken,
        output imm,
        output rs1_val,
        input  pc,
        input  pc_plus4,
        input  rom_addr,
        input  commit
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch and execution control: owns the PC, computes next-PC and
// gates retirement for free-run, single-step, breakpoint and halt operation.
module fetch_ctrl #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 6,
    parameter int DEB_MAX = 1000000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cpu_en,
    input  logic              run_mode,
    input  logic              step_btn,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] end_addr,
    fetch_ctrl_if.master      bus,
    output logic [1:0]        state,
    output logic              halted
);

    localparam int CNT_W = 24;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_MAX - 1);

    localparam logic [1:0] S_WAIT = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_EXEC = 2'b10;
    localparam logic [1:0] S_HALT = 2'b11;

    logic              r_sync0;
    logic              r_sync1;
    logic              r_deb;
    logic              r_deb_d;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_state;
    logic [XLEN-1:0]   r_pc;

    logic              w_step_pulse;
    logic [XLEN-1:0]   w_npc_raw;
    logic [XLEN-1:0]   w_npc;
    logic [ADDR_W-1:0] w_rom_addr;
    logic              w_at_end;
    logic              w_bp_hit;
    logic              w_commit;
    logic [1:0]        w_state_nxt;

    // The counter restarts whenever the synchronised level agrees with the
    // accepted level, so only an unbroken run of DEB_MAX samples flips it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_deb   <= 1'b0;
            r_deb_d <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync0 <= step_btn;
            r_sync1 <= r_sync0;
            r_deb_d <= r_deb;
            if (r_sync1 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == DEB_LAST) begin
                r_deb <= r_sync1;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_step_pulse = r_deb & ~r_deb_d;

    always_comb begin
        w_npc_raw = r_pc + XLEN'(4);
        case (bus.npc_sel)
            2'b00: w_npc_raw = r_pc + XLEN'(4);
            2'b01: w_npc_raw = bus.br_taken ? (r_pc + bus.imm) : (r_pc + XLEN'(4));
            2'b10: w_npc_raw = r_pc + bus.imm;
            2'b11: w_npc_raw = bus.rs1_val + bus.imm;
        endcase
        w_npc = {w_npc_raw[XLEN-1:2], 2'b00};
    end

    assign w_rom_addr = r_pc[ADDR_W+1:2];
    assign w_at_end   = (w_rom_addr == end_addr);
    assign w_bp_hit   = bp_en & (w_rom_addr == bp_addr);

    // Reset in the same cycle as cpu_en must suppress the retire strobe.
    assign w_commit = rstn & cpu_en &
                      (((r_state == S_RUN) & ~w_bp_hit) | (r_state == S_EXEC));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT: begin
                if (run_mode) begin
                    w_state_nxt = S_RUN;
                end else if (w_step_pulse) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_RUN: begin
                if (cpu_en & w_bp_hit) begin
                    w_state_nxt = S_WAIT;
                end else if (cpu_en & w_at_end) begin
                    w_state_nxt = S_HALT;
                end else if (!run_mode) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_EXEC: begin
                if (cpu_en) begin
                    w_state_nxt = w_at_end ? S_HALT : S_WAIT;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The last instruction still retires, but the PC stays on it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pc <= '0;
        end else if (w_commit && !w_at_end) begin
            r_pc <= w_npc;
        end
    end

    assign bus.pc       = r_pc;
    assign bus.pc_plus4 = r_pc + XLEN'(4);
    assign bus.rom_addr = w_rom_addr;
    assign bus.commit   = w_commit;
    assign state        = r_state;
    assign halted       = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed and randomized checks of fetch_ctrl against a reference model.
module tb_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       cpu_en;
    logic       run_mode;
    logic       step_btn;
    logic       bp_en;
    logic [5:0] bp_addr;
    logic [5:0] end_addr;
    logic [1:0] state;
    logic       halted;

    int n_tests   = 0;
    int n_fail    = 0;
    int n_commits = 0;

    fetch_ctrl_if #(.XLEN(32), .ADDR_W(6)) bus ();

    fetch_ctrl #(.XLEN(32), .ADDR_W(6), .DEB_MAX(4)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .cpu_en   (cpu_en),
        .run_mode (run_mode),
        .step_btn (step_btn),
        .bp_en    (bp_en),
        .bp_addr  (bp_addr),
        .end_addr (end_addr),
        .bus      (bus.master),
        .state    (state),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish, expected finish before 300000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_tests++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycle(input logic en, output logic cm);
        cpu_en = en;
        #2;
        cm = bus.commit;
        if (cm) n_commits++;
        @(posedge clk);
        #1;
        cpu_en = 1'b0;
    endtask

    task automatic do_reset();
        rstn     = 1'b0;
        cpu_en   = 1'b0;
        step_btn = 1'b0;
        run_mode = 1'b0;
        bp_en    = 1'b0;
        bus.npc_sel = 2'b00;
        repeat (2) tick();
        rstn = 1'b1;
    endtask

    task automatic press_until_exec(input string tag);
        step_btn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (state == 2'b10) break;
            tick();
        end
        chk(tag, state, 2'b10);
    endtask

    // Next PC from the flow rules: target by kind, then word-aligned.
    function automatic logic [31:0] ref_npc(input logic [31:0] pc, input logic [1:0] sel,
                                            input logic taken, input logic [31:0] imm,
                                            input logic [31:0] rs1);
        logic [31:0] t;
        if (sel == 2'd3)                   t = rs1 + imm;
        else if (sel == 2'd2)              t = pc + imm;
        else if (sel == 2'd1 && taken)     t = pc + imm;
        else                               t = pc + 32'd4;
        return t & ~32'h3;
    endfunction

    logic [1:0]  t_sel [9] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3};
    logic        t_tk  [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] t_imm [9] = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'h0, 32'h0, 32'hFFFF_FFF8,
                               32'hFFFF_FFF8, 32'h10, 32'h2};
    logic [31:0] t_rs1 [9] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h23};
    logic [31:0] t_exp [9] = '{32'h4, 32'h8, 32'h0, 32'h4, 32'h8, 32'hC, 32'h4, 32'h14, 32'h24};

    initial begin
        logic        cm;
        logic        exp_cm;
        logic        m_halt;
        logic        saw;
        logic [31:0] m_pc;
        logic [31:0] pc_before;
        logic [31:0] rnd;
        int          cnt;
        int          commits_before;

        rstn = 1'b0; cpu_en = 1'b0; run_mode = 1'b0; step_btn = 1'b0;
        bp_en = 1'b0; bp_addr = '0; end_addr = '0;
        bus.npc_sel = 2'b00; bus.br_taken = 1'b0; bus.imm = '0; bus.rs1_val = '0;
        tick();

        // Reset values, with cpu_en high while reset is held.
        cpu_en = 1'b1;
        #2;
        chk("rst_commit", bus.commit, 1'b0);
        tick();
        cpu_en = 1'b0;
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_pc_plus4", bus.pc_plus4, 32'h4);
        chk("rst_rom_addr", bus.rom_addr, 6'd0);
        chk("rst_state", state, 2'b00);
        chk("rst_halted", halted, 1'b0);

        // Free run to the programme end.
        run_mode = 1'b1; end_addr = 6'd5; rstn = 1'b1;
        m_pc = 32'h0; cnt = 0;
        for (int c = 0; c < 60; c++) begin
            run_cycle((c % 4) == 3, cm);
            if (cm) begin
                cnt++;
                if (m_pc[7:2] != end_addr) m_pc = m_pc + 32'd4;
                chk("run_pc", bus.pc, m_pc);
            end
        end
        chk("run_commits", cnt, 6);
        chk("run_pc_final", bus.pc, 32'h14);
        chk("run_halted", halted, 1'b1);
        chk("run_state", state, 2'b11);

        // Branch, JAL and JALR flow.
        do_reset();
        run_mode = 1'b1; end_addr = 6'd50;
        tick();
        for (int k = 0; k < 9; k++) begin
            bus.npc_sel = t_sel[k]; bus.br_taken = t_tk[k];
            bus.imm = t_imm[k]; bus.rs1_val = t_rs1[k];
            run_cycle(1'b1, cm);
            chk("flow_commit", cm, 1'b1);
            chk("flow_pc", bus.pc, t_exp[k]);
        end
        chk("flow_rom_addr", bus.rom_addr, 6'd9);
        chk("flow_pc_plus4", bus.pc_plus4, 32'h28);

        // Breakpoint stop, then a single step over the breakpoint word.
        do_reset();
        run_mode = 1'b1; bp_en = 1'b1; bp_addr = 6'd3; end_addr = 6'd50;
        bus.npc_sel = 2'b00;
        tick();
        cnt = 0;
        for (int c = 0; c < 40 && cnt < 3; c++) begin
            run_cycle((c % 2) == 1, cm);
            if (cm) cnt++;
        end
        chk("bp_pre_pc", bus.pc, 32'hC);
        run_cycle(1'b1, cm);
        chk("bp_no_commit", cm, 1'b0);
        run_mode = 1'b0;
        chk("bp_state", state, 2'b00);
        chk("bp_pc", bus.pc, 32'hC);
        tick();
        chk("bp_state_hold", state, 2'b00);
        press_until_exec("bp_press_exec");
        run_cycle(1'b1, cm);
        chk("step_commit", cm, 1'b1);
        chk("step_pc", bus.pc, 32'h10);
        chk("step_state", state, 2'b00);
        step_btn = 1'b0;
        repeat (10) tick();

        // Debounce: a short glitch must not step.
        step_btn = 1'b1;
        repeat (3) tick();
        step_btn = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (state != 2'b00) saw = 1'b1;
        end
        chk("glitch_no_step", saw, 1'b0);

        // A long press steps once; a second press during EXEC is dropped.
        commits_before = n_commits;
        pc_before = bus.pc;
        step_btn = 1'b1;
        repeat (10) tick();
        step_btn = 1'b0;
        chk("deb_exec", state, 2'b10);
        repeat (10) tick();
        step_btn = 1'b1;
        repeat (10) tick();
        step_btn = 1'b0;
        chk("deb_exec_hold", state, 2'b10);
        run_cycle(1'b1, cm);
        chk("deb_commit", cm, 1'b1);
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            run_cycle(1'b1, cm);
            if (state != 2'b00) saw = 1'b1;
        end
        chk("deb_no_queued_step", saw, 1'b0);
        chk("deb_commit_count", n_commits - commits_before, 1);
        chk("deb_pc", bus.pc, pc_before + 32'd4);

        // Reset in the cpu_en cycle of an EXEC at pc 8.
        do_reset();
        run_mode = 1'b1; end_addr = 6'd50;
        tick();
        run_cycle(1'b1, cm);
        run_cycle(1'b1, cm);
        run_mode = 1'b0;
        tick();
        chk("rm_pre_pc", bus.pc, 32'h8);
        press_until_exec("rm_press_exec");
        rstn = 1'b0; cpu_en = 1'b1;
        #2;
        chk("rm_commit", bus.commit, 1'b0);
        tick();
        cpu_en = 1'b0; rstn = 1'b1; step_btn = 1'b0;
        chk("rm_pc", bus.pc, 32'h0);
        chk("rm_state", state, 2'b00);

        // ROM address wrap.
        do_reset();
        run_mode = 1'b1; end_addr = 6'd40;
        tick();
        bus.npc_sel = 2'b10; bus.imm = 32'hFC;
        run_cycle(1'b1, cm);
        chk("wrap_pc_fc", bus.pc, 32'hFC);
        chk("wrap_rom_63", bus.rom_addr, 6'd63);
        bus.npc_sel = 2'b00;
        run_cycle(1'b1, cm);
        chk("wrap_commit", cm, 1'b1);
        chk("wrap_pc", bus.pc, 32'h100);
        chk("wrap_rom_0", bus.rom_addr, 6'd0);

        // Randomized free run against the reference model.
        do_reset();
        run_mode = 1'b1;
        end_addr = 6'($urandom_range(8, 63));
        tick();
        m_pc = 32'h0; m_halt = 1'b0;
        for (int i = 0; i < 300; i++) begin
            rnd = $urandom;
            bus.npc_sel  = 2'($urandom_range(0, 3));
            bus.br_taken = 1'($urandom_range(0, 1));
            bus.imm      = {{24{rnd[7]}}, rnd[7:0]};
            bus.rs1_val  = {24'h0, rnd[15:8]};
            exp_cm = ($urandom_range(0, 2) == 0);
            run_cycle(exp_cm, cm);
            exp_cm = exp_cm & ~m_halt;
            chk("rnd_commit", cm, exp_cm);
            if (exp_cm) begin
                if (m_pc[7:2] == end_addr) m_halt = 1'b1;
                else m_pc = ref_npc(m_pc, bus.npc_sel, bus.br_taken, bus.imm, bus.rs1_val);
            end
            chk("rnd_pc", bus.pc, m_pc);
            chk("rnd_halted", halted, m_halt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
